// File: rtl/add_tdest_from_vlan_tag_if.sv
// Byte-wide AXI4-Stream bundle used on both sides of the tdest stage.
interface add_tdest_from_vlan_tag_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic [1:0] tuser;
  logic [2:0] tdest;

  modport master (output tdata, output tvalid, output tlast, output tuser, output tdest,
                  input  tready);
  modport slave  (input  tdata, input  tvalid, input  tlast, input  tuser,
                  output tready);
endinterface

// File: rtl/add_tdest_from_vlan_tag.sv
// Buffers the Ethernet header of each frame, maps the 802.1Q PCP to a queue
// number and presents it on m_axis.tdest for every beat of that frame.
// Byte stream, tlast and tuser pass through unchanged; one frame in flight.
module add_tdest_from_vlan_tag #(
  parameter int unsigned HDR_BYTES = 16,
  parameter logic [15:0] VLAN_TPID = 16'h8100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] pcp0_tdest,
  input  logic [2:0] pcp1_tdest,
  input  logic [2:0] pcp2_tdest,
  input  logic [2:0] pcp3_tdest,
  input  logic [2:0] pcp4_tdest,
  input  logic [2:0] pcp5_tdest,
  input  logic [2:0] pcp6_tdest,
  input  logic [2:0] pcp7_tdest,
  input  logic [2:0] untagged_tdest,
  add_tdest_from_vlan_tag_if.slave  s_axis,
  add_tdest_from_vlan_tag_if.master m_axis
);

  localparam int unsigned AW = $clog2(HDR_BYTES);

  // Header byte positions, counted from 0 within the frame.
  localparam logic [AW:0] IDX_TPID_HI = (AW+1)'(HDR_BYTES - 4);
  localparam logic [AW:0] IDX_TPID_LO = (AW+1)'(HDR_BYTES - 3);
  localparam logic [AW:0] IDX_TCI_HI  = (AW+1)'(HDR_BYTES - 2);
  localparam logic [AW:0] IDX_LAST    = (AW+1)'(HDR_BYTES - 1);
  localparam logic [AW:0] CNT_FULL    = (AW+1)'(HDR_BYTES);

  typedef enum logic {COLLECT, STREAM} state_t;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] user;
    logic       last;
  } entry_t;

  state_t        r_state;
  entry_t        r_mem [HDR_BYTES];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_active;
  logic          r_in_done;
  logic [7:0]    r_tpid_hi;
  logic [7:0]    r_tpid_lo;
  logic [2:0]    r_pcp;
  logic [2:0]    r_tdest;

  logic          w_s_ready;
  logic          w_m_valid;
  logic          w_push;
  logic          w_pop;
  logic          w_decide;
  logic          w_tagged;
  logic [2:0]    w_pcp_tdest;
  entry_t        w_head;

  assign w_head    = r_mem[r_rd_ptr];
  assign w_m_valid = (r_state == STREAM) && (r_count != '0);
  assign w_pop     = w_m_valid && m_axis.tready;

  // In COLLECT the FIFO never holds more than HDR_BYTES-1 entries, so the
  // ready term only has to consider fullness while streaming.
  always_comb begin
    w_s_ready = 1'b0;
    if (r_active) begin
      if (r_state == COLLECT) w_s_ready = 1'b1;
      else                    w_s_ready = !r_in_done && ((r_count != CNT_FULL) || w_pop);
    end
  end

  assign w_push   = s_axis.tvalid && w_s_ready;
  assign w_decide = w_push && (r_state == COLLECT) && ((r_count == IDX_LAST) || s_axis.tlast);
  assign w_tagged = (r_count == IDX_LAST) && ({r_tpid_hi, r_tpid_lo} == VLAN_TPID);

  // PCP to queue-number lookup from the quasi-static configuration ports.
  always_comb begin
    w_pcp_tdest = pcp0_tdest;
    case (r_pcp)
      3'd0:    w_pcp_tdest = pcp0_tdest;
      3'd1:    w_pcp_tdest = pcp1_tdest;
      3'd2:    w_pcp_tdest = pcp2_tdest;
      3'd3:    w_pcp_tdest = pcp3_tdest;
      3'd4:    w_pcp_tdest = pcp4_tdest;
      3'd5:    w_pcp_tdest = pcp5_tdest;
      3'd6:    w_pcp_tdest = pcp6_tdest;
      default: w_pcp_tdest = pcp7_tdest;
    endcase
  end

  // FIFO storage; cleared on reset so the output bus reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < HDR_BYTES; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= '{data: s_axis.tdata, user: s_axis.tuser, last: s_axis.tlast};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Capture TPID and PCP while the header is being collected; the FIFO is
  // empty at frame start, so the occupancy doubles as the byte index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tpid_hi <= '0;
      r_tpid_lo <= '0;
      r_pcp     <= '0;
    end else if (w_push && (r_state == COLLECT)) begin
      if (r_count == IDX_TPID_HI) r_tpid_hi <= s_axis.tdata;
      if (r_count == IDX_TPID_LO) r_tpid_lo <= s_axis.tdata;
      if (r_count == IDX_TCI_HI)  r_pcp     <= s_axis.tdata[7:5];
    end
  end

  // Frame FSM: header decision, tdest latch, end-of-frame return.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= COLLECT;
      r_tdest   <= '0;
      r_in_done <= 1'b0;
      r_active  <= 1'b0;
    end else begin
      r_active <= 1'b1;
      if (w_push && s_axis.tlast) r_in_done <= 1'b1;
      case (r_state)
        COLLECT: begin
          if (w_decide) begin
            r_tdest <= w_tagged ? w_pcp_tdest : untagged_tdest;
            r_state <= STREAM;
          end
        end
        STREAM: begin
          if (w_pop && w_head.last) begin
            r_state   <= COLLECT;
            r_in_done <= 1'b0;
          end
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

  assign s_axis.tready = w_s_ready;
  assign m_axis.tvalid = w_m_valid;
  assign m_axis.tdata  = w_head.data;
  assign m_axis.tuser  = w_head.user;
  assign m_axis.tlast  = w_head.last;
  assign m_axis.tdest  = r_tdest;

endmodule

// File: tb/tb_add_tdest_from_vlan_tag.sv
// Directed frame table plus hand-written reset sequences for the tdest stage.
module tb_add_tdest_from_vlan_tag;

  logic clk = 1'b0;
  logic rst;
  logic [2:0] pcp [8];
  logic [2:0] untagged;

  always #5 clk = ~clk;

  add_tdest_from_vlan_tag_if s_if ();
  add_tdest_from_vlan_tag_if m_if ();

  assign s_if.tdest = '0;

  add_tdest_from_vlan_tag #(
    .HDR_BYTES (16),
    .VLAN_TPID (16'h8100)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .pcp0_tdest     (pcp[0]),
    .pcp1_tdest     (pcp[1]),
    .pcp2_tdest     (pcp[2]),
    .pcp3_tdest     (pcp[3]),
    .pcp4_tdest     (pcp[4]),
    .pcp5_tdest     (pcp[5]),
    .pcp6_tdest     (pcp[6]),
    .pcp7_tdest     (pcp[7]),
    .untagged_tdest (untagged),
    .s_axis         (s_if),
    .m_axis         (m_if)
  );

  // mode 0: always valid/ready; 1: valid toggles /20, ready toggles /50;
  // 2: output held off for 40 cycles to fill the FIFO.
  typedef struct {
    int unsigned len;
    logic [15:0] tpid;
    logic [7:0]  tci;
    int unsigned mode;
    logic [2:0]  exp_tdest;
    bit          hold;
  } vec_t;

  vec_t tbl [16];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gen_byte(input int unsigned f, input int unsigned i,
                                          input logic [15:0] tpid, input logic [7:0] tci);
    if (i == 12) return tpid[15:8];
    if (i == 13) return tpid[7:0];
    if (i == 14) return tci;
    return 8'(f * 37 + i * 13 + 5);
  endfunction

  task automatic run_frame(input int unsigned f, input vec_t v);
    int unsigned in_i = 0, out_i = 0, cyc = 0;
    int unsigned infl = 0, max_infl = 0, dec_cyc = 0, first_v = 0;
    int unsigned dec_idx;
    bit seen_v = 0, prev_stall = 0, saw_block = 0, vld_ok, rdy;
    bit s_fire, m_fire;
    logic [7:0] pd; logic pl; logic [1:0] pu; logic [2:0] pt;
    dec_idx = (v.len < 16) ? v.len - 1 : 15;
    while (out_i < v.len && cyc < 3000) begin
      @(negedge clk);
      case (v.mode)
        1:       begin vld_ok = ((cyc / 20) % 2) == 0; rdy = ((cyc / 50) % 2) == 0; end
        2:       begin vld_ok = 1'b1; rdy = (cyc >= 40); end
        default: begin vld_ok = 1'b1; rdy = 1'b1; end
      endcase
      if (in_i < v.len) begin
        s_if.tvalid = vld_ok;
        s_if.tdata  = gen_byte(f, in_i, v.tpid, v.tci);
        s_if.tlast  = (in_i == v.len - 1);
        s_if.tuser  = 2'(f + in_i);
      end else if (v.hold) begin
        s_if.tvalid = 1'b1;
        s_if.tdata  = gen_byte(f + 1, 0, 16'h0, 8'h0);
        s_if.tlast  = 1'b0;
        s_if.tuser  = 2'(f + 1);
      end else begin
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
      end
      m_if.tready = rdy;
      #1;
      if (prev_stall) begin
        chk("stall_valid", m_if.tvalid, 1);
        chk("stall_data", m_if.tdata, pd);
        chk("stall_last", m_if.tlast, pl);
        chk("stall_user", m_if.tuser, pu);
        chk("stall_tdest", m_if.tdest, pt);
      end
      prev_stall = m_if.tvalid && !m_if.tready;
      pd = m_if.tdata; pl = m_if.tlast; pu = m_if.tuser; pt = m_if.tdest;
      if (m_if.tvalid && !seen_v) begin seen_v = 1; first_v = cyc; end
      if (in_i >= v.len && v.hold) chk("next_frame_blocked", s_if.tready, 0);
      if (in_i < v.len && s_if.tvalid && !s_if.tready) saw_block = 1;
      s_fire = s_if.tvalid && s_if.tready && (in_i < v.len);
      m_fire = m_if.tvalid && m_if.tready;
      if (m_fire) begin
        chk("beat_data", m_if.tdata, gen_byte(f, out_i, v.tpid, v.tci));
        chk("beat_last", m_if.tlast, (out_i == v.len - 1));
        chk("beat_user", m_if.tuser, 2'(f + out_i));
        chk("beat_tdest", m_if.tdest, v.exp_tdest);
        out_i++;
        infl--;
      end
      if (s_fire) begin
        if (in_i == dec_idx) dec_cyc = cyc;
        in_i++;
        infl++;
        if (infl > max_infl) max_infl = infl;
      end
      cyc++;
    end
    chk("frame_beats", out_i, v.len);
    if (v.mode == 0) chk("first_valid_latency", first_v, dec_cyc + 1);
    if (v.mode == 2) begin
      chk("fifo_fill", max_infl, 16);
      chk("input_backpressured", saw_block, 1);
    end
  endtask

  initial begin
    int unsigned k;
    vec_t v;
    pcp[0] = 3'd1; pcp[1] = 3'd0; pcp[2] = 3'd6; pcp[3] = 3'd7;
    pcp[4] = 3'd2; pcp[5] = 3'd3; pcp[6] = 3'd4; pcp[7] = 3'd5;
    untagged = 3'd1;

    tbl[0]  = '{64, 16'h8100, 8'hA0, 0, 3'd3, 1'b0};
    tbl[1]  = '{60, 16'h0800, 8'h45, 0, 3'd1, 1'b0};
    tbl[2]  = '{64, 16'h8100, 8'h40, 0, 3'd6, 1'b0};
    tbl[3]  = '{64, 16'h8100, 8'h60, 0, 3'd7, 1'b0};
    tbl[4]  = '{10, 16'h8100, 8'hE0, 0, 3'd1, 1'b0};
    tbl[5]  = '{16, 16'h8100, 8'h20, 0, 3'd0, 1'b0};
    tbl[6]  = '{15, 16'h8100, 8'h20, 0, 3'd1, 1'b0};
    tbl[7]  = '{1,  16'h8100, 8'h00, 0, 3'd1, 1'b0};
    tbl[8]  = '{30, 16'h8101, 8'hA0, 0, 3'd1, 1'b0};
    tbl[9]  = '{17, 16'h8100, 8'hC0, 0, 3'd4, 1'b0};
    tbl[10] = '{64, 16'h8100, 8'h80, 1, 3'd2, 1'b0};
    tbl[11] = '{60, 16'h0800, 8'h45, 1, 3'd1, 1'b0};
    tbl[12] = '{40, 16'h8100, 8'h7F, 1, 3'd7, 1'b0};
    tbl[13] = '{64, 16'h8100, 8'h00, 2, 3'd1, 1'b0};
    tbl[14] = '{64, 16'h8100, 8'hE0, 0, 3'd5, 1'b1};
    tbl[15] = '{64, 16'h8100, 8'h20, 0, 3'd0, 1'b0};

    rst = 1'b1;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; s_if.tuser = '0;
    m_if.tready = 1'b0;
    #2;
    chk("rst_m_tvalid", m_if.tvalid, 0);
    chk("rst_m_tdata", m_if.tdata, 0);
    chk("rst_m_tlast", m_if.tlast, 0);
    chk("rst_m_tuser", m_if.tuser, 0);
    chk("rst_m_tdest", m_if.tdest, 0);
    chk("rst_s_tready", s_if.tready, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_s_tready", s_if.tready, 1);
    chk("post_rst_m_tvalid", m_if.tvalid, 0);

    for (int i = 0; i < 16; i++) run_frame(i, tbl[i]);

    // Mid-frame reset: hold output off so the FIFO holds a partial frame.
    k = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      s_if.tvalid = 1'b1;
      s_if.tdata  = gen_byte(30, k, 16'h8100, 8'hC0);
      s_if.tlast  = 1'b0;
      s_if.tuser  = 2'(30 + k);
      m_if.tready = 1'b0;
      #1;
      if (s_if.tvalid && s_if.tready) k++;
    end
    chk("midrst_pre_valid", m_if.tvalid, 1);
    chk("midrst_pre_tdest", m_if.tdest, 4);
    chk("midrst_pre_accepted", k, 16);
    #1 rst = 1'b1;
    #1;
    chk("midrst_m_tvalid", m_if.tvalid, 0);
    chk("midrst_m_tdata", m_if.tdata, 0);
    chk("midrst_m_tlast", m_if.tlast, 0);
    chk("midrst_m_tuser", m_if.tuser, 0);
    chk("midrst_m_tdest", m_if.tdest, 0);
    chk("midrst_s_tready", s_if.tready, 0);
    s_if.tvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    v = '{40, 16'h8100, 8'h80, 0, 3'd2, 1'b0};
    run_frame(31, v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/add_tdest_from_vlan_tag.md
Name: add_tdest_from_vlan_tag

Overview:
- Byte-wide AXI4-Stream stage in the CBS/TSN switch datapath.
- Inspects each Ethernet frame's 802.1Q tag, maps the 3-bit PCP to a queue number, and drives that number on m_axis_tdest for every beat of the frame.
- Frame data, tlast and tuser pass through unmodified, so the output byte stream equals the input byte stream.
- Feeds the per-class queue/shaper selection downstream.

Parameters:
- HDR_BYTES, 16, bytes buffered before the tdest decision: DA(6) + SA(6) + TPID(2) + TCI(2).
- VLAN_TPID, 16'h8100, TPID value that marks a frame as tagged.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- pcp0_tdest … pcp7_tdest  in  3 each  queue number for PCP 0 … 7 (eight separate ports, quasi-static)
- untagged_tdest  in  3  queue number for untagged or short frames
- s_axis_tdata  in  8  input byte
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  last byte of frame
- s_axis_tuser  in  2  sideband, carried per beat
- m_axis_tdata  out  8  output byte
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  last byte of frame
- m_axis_tuser  out  2  sideband, aligned with its byte
- m_axis_tdest  out  3  queue number, constant for the whole frame

Behaviour:
- Reset (asynchronous, active-high): m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdest=0, buffer count=0, state=COLLECT. s_axis_tready=0 while rst is high and 1 after rst is released. Reset mid-frame discards all buffered bytes; the next frame is parsed from its first byte.
- Storage: 16-entry FIFO; each entry holds {tdata, tuser, tlast}.
- Beat transfer: a beat is accepted only when tvalid && tready. Every accepted byte is emitted exactly once, in order.
- COLLECT state:
  - s_axis_tready=1 and m_axis_tvalid=0.
  - Accepted bytes are written to the FIFO.
  - The decision is made when the 16th byte is accepted, or when a byte with tlast is accepted (whichever comes first).
- Decision rule (registered, takes effect the next cycle):
  - If at least 16 bytes were received and byte12:byte13 == 16'h8100, then tdest = pcpN_tdest with N = byte14[7:5].
  - Otherwise tdest = untagged_tdest. This includes frames shorter than 16 bytes.
  - The result is latched into m_axis_tdest and the state moves to STREAM.
  - Latency: the first m_axis_tvalid is asserted the cycle after the decision byte is accepted.
- STREAM state:
  - m_axis_tvalid = (FIFO not empty); the FIFO head drives tdata/tuser/tlast.
  - s_axis_tready = (input tlast not yet accepted for this frame) && (FIFO not full, or a pop happens this cycle).
  - Simultaneous push and pop is allowed and leaves the count unchanged.
  - m_axis_tdest holds its value and must not change while m_axis_tvalid=1 and m_axis_tready=0.
  - AXI rule: once m_axis_tvalid is asserted, it and the data stay stable until accepted.
- End of frame: when the beat with m_axis_tlast is accepted, the FIFO is empty, so return to COLLECT. Bytes of the next frame are not accepted before this point (one frame in flight).
- Backpressure: with m_axis_tready low, the FIFO fills to 16 and s_axis_tready deasserts; no byte is lost or duplicated.
- pcpN_tdest and untagged_tdest are sampled only at the decision cycle.

Test Plan:
- Config pcp0..7 = 1,0,6,7,2,3,4,5 and untagged = 1. Tagged frame, TPID 8100, TCI byte14 = 0xA0 (PCP5), 64 bytes → output bytes identical and m_axis_tdest = 3 on all beats.
- Untagged IPv4 frame (bytes12-13 = 0x0800), 60 bytes → identical output, tdest = 1. A tagged PCP2 frame → tdest = 6; PCP3 → 7.
- Frame of 10 bytes → 10 identical bytes out, tlast on the 10th byte, tdest = 1.
- Input valid toggling every 20 cycles and output ready toggling every 50 cycles, over a repeated pcap-style frame list → byte-exact match, tlast aligned, tdest stable under stall.
- Back-to-back frames PCP7 then PCP1 → tdest 5 for the first frame, then 0 for the second, changing only after the first frame's tlast.
- Assert rst mid-frame, then send a fresh tagged PCP4 frame → outputs go to 0 asynchronously, then the frame exits intact with tdest = 2.
